// File: rtl/smem_port_arbiter.sv
// smem_port_arbiter
//   Round-robin arbiter sharing one single-ported shared-memory bank between
//   N_REQ cores. One request is served at a time: IDLE picks a requester,
//   ISSUE drives the bank for one cycle, WAIT covers the bank read latency
//   (loads only), RESP pulses the requester's done bit.
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   req_rd, req_wr  : per-core level load/store requests (held until done)
//   req_addr        : core k address at [ADDR_W*k +: ADDR_W]
//   req_wdata       : core k store data at [DATA_W*k +: DATA_W]
//   done            : one-cycle completion pulse per core
//   rdata           : per-core load result slots, held until next load
//   mem_en/mem_we   : bank access strobe / write enable
//   mem_addr/wdata  : bank address / write data
//   mem_rdata       : bank read data, valid MEM_LAT cycles after mem_en
//   busy, grant_id  : arbiter busy flag and index of requester being served
module smem_port_arbiter #(
  parameter int N_REQ   = 16,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_rd,
  input  logic [N_REQ-1:0]         req_wr,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ*DATA_W-1:0]  rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  wait_cnt;

  logic [N_REQ-1:0]  pending;
  logic              any_pending;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [N_REQ-1:0]  grant_onehot;

  assign pending      = req_rd | req_wr;
  assign any_pending  = |pending;
  assign grant_onehot = N_REQ'(1) << grant_id;

  // Round-robin scan: first pending index strictly after ptr, wrapping.
  // ptr itself is visited last, so a lone requester is still re-granted.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= ID_W'(N_REQ - 1);
      wait_cnt  <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      done      <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        // IDLE: requests are sampled only here; a store wins over a load
        IDLE: begin
          if (any_pending) begin
            grant_id  <= sel;
            ptr       <= sel;
            mem_addr  <= req_addr[sel*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[sel*DATA_W +: DATA_W];
            mem_we    <= req_wr[sel];
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        // ISSUE: single-cycle bank strobe
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            done  <= grant_onehot;
            state <= RESP;
          end else begin
            wait_cnt <= CNT_W'(MEM_LAT);
            state    <= WAIT;
          end
        end
        // WAIT: last count coincides with the bank's read data
        WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            rdata[grant_id*DATA_W +: DATA_W] <= mem_rdata;
            done  <= grant_onehot;
            state <= RESP;
          end
        end
        // RESP: done pulse ends; the following IDLE cycle keeps a stale
        // request from being re-granted
        RESP: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smem_port_arbiter.sv
module tb_smem_port_arbiter;
  localparam int N  = 16;
  localparam int AW = 12;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance with MEM_LAT = 1
  logic [N-1:0]    req_rd1, req_wr1, done1;
  logic [N*AW-1:0] req_addr1;
  logic [N*DW-1:0] req_wdata1, rdata1;
  logic            mem_en1, mem_we1, busy1;
  logic [AW-1:0]   mem_addr1;
  logic [DW-1:0]   mem_wdata1, mem_rdata1;
  logic [3:0]      grant_id1;

  // instance with MEM_LAT = 3
  logic [N-1:0]    req_rd3, req_wr3, done3;
  logic [N*AW-1:0] req_addr3;
  logic [N*DW-1:0] req_wdata3, rdata3;
  logic            mem_en3, mem_we3, busy3;
  logic [AW-1:0]   mem_addr3;
  logic [DW-1:0]   mem_wdata3, mem_rdata3;
  logic [3:0]      grant_id3;

  smem_port_arbiter #(.N_REQ(N), .ID_W(4), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(rst_n), .req_rd(req_rd1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .done(done1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1),
    .grant_id(grant_id1));

  smem_port_arbiter #(.N_REQ(N), .ID_W(4), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u3 (
    .clk(clk), .reset(rst_n), .req_rd(req_rd3), .req_wr(req_wr3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .done(done3), .rdata(rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3),
    .grant_id(grant_id3));

  // bank models: read-only contents preset by the tests
  logic [DW-1:0] bank1 [0:4095];
  logic [DW-1:0] bank3 [0:4095];
  logic [DW-1:0] p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    mem_rdata1 <= mem_en1 ? bank1[mem_addr1] : 8'h00;
    p3_0 <= mem_en3 ? bank3[mem_addr3] : 8'h00;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign mem_rdata3 = p3_2;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 4'(id);
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_rd1 = '0; req_wr1 = '0; req_addr1 = '0; req_wdata1 = '0;
    req_rd3 = '0; req_wr3 = '0; req_addr3 = '0; req_wdata3 = '0;
    for (int i = 0; i < 4096; i++) begin
      bank1[i] = 8'h00;
      bank3[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done1 !== '0) begin failures++; $display("FAIL reset_done got=%h want=0", done1); end
    checks++; if (rdata1 !== '0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata1); end
    checks++; if ({mem_en1, mem_we1, busy1} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b want=000", {mem_en1, mem_we1, busy1}); end
    checks++; if ({mem_addr1, mem_wdata1, grant_id1} !== '0) begin failures++; $display("FAIL reset_bus got=%h want=0", {mem_addr1, mem_wdata1, grant_id1}); end
    checks++; if ({rdata3, done3, busy3, mem_en3} !== '0) begin failures++; $display("FAIL reset_u3 got=%h want=0", {rdata3, done3, busy3, mem_en3}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy1); end
  endtask

  task automatic test_single_store();
    exp_t e;
    // cycle T
    req_addr1[3*AW +: AW]  = 12'h0A5;
    req_wdata1[3*DW +: DW] = 8'h3C;
    req_wr1[3] = 1'b1;
    push_exp(3, 8'h00);
    @(posedge clk); #1;  // T+1
    checks++; if ({mem_en1, mem_we1} !== 2'b11) begin failures++; $display("FAIL store_en_we got=%b want=11", {mem_en1, mem_we1}); end
    checks++; if (mem_addr1 !== 12'h0A5) begin failures++; $display("FAIL store_addr got=%h want=0a5", mem_addr1); end
    checks++; if (mem_wdata1 !== 8'h3C) begin failures++; $display("FAIL store_wdata got=%h want=3c", mem_wdata1); end
    checks++; if ({busy1, grant_id1} !== 5'h13) begin failures++; $display("FAIL store_grant got=%h want=13", {busy1, grant_id1}); end
    @(posedge clk); #1;  // T+2
    e = sb.pop_front();
    checks++; if (done1 !== (16'(1) << e.id)) begin failures++; $display("FAIL store_done got=%h want=%h", done1, 16'(1) << e.id); end
    checks++; if (mem_en1 !== 1'b0) begin failures++; $display("FAIL store_en_one_cycle got=%b want=0", mem_en1); end
    req_wr1[3] = 1'b0;
    @(posedge clk); #1;  // T+3
    checks++; if ({busy1, done1} !== '0) begin failures++; $display("FAIL store_end got=%h want=0", {busy1, done1}); end
    checks++; if (rdata1 !== '0) begin failures++; $display("FAIL store_rdata got=%h want=0", rdata1); end
  endtask

  task automatic test_single_load();
    exp_t e;
    logic [N*DW-1:0] mask;
    bank1[12'h010] = 8'h7E;
    req_addr1[5*AW +: AW] = 12'h010;
    req_rd1[5] = 1'b1;  // cycle T
    push_exp(5, 8'h7E);
    @(posedge clk); #1;  // T+1
    checks++; if ({mem_en1, mem_we1, mem_addr1} !== {2'b10, 12'h010}) begin failures++; $display("FAIL load_issue got=%h want=%h", {mem_en1, mem_we1, mem_addr1}, {2'b10, 12'h010}); end
    @(posedge clk); #1;  // T+2
    checks++; if (done1 !== '0) begin failures++; $display("FAIL load_early_done got=%h want=0", done1); end
    @(posedge clk); #1;  // T+3
    e = sb.pop_front();
    checks++; if (done1 !== (16'(1) << e.id)) begin failures++; $display("FAIL load_done got=%h want=%h", done1, 16'(1) << e.id); end
    checks++; if (rdata1[int'(e.id)*DW +: DW] !== e.data) begin failures++; $display("FAIL load_slot got=%h want=%h", rdata1[int'(e.id)*DW +: DW], e.data); end
    mask = '1;
    mask[5*DW +: DW] = '0;
    checks++; if ((rdata1 & mask) !== '0) begin failures++; $display("FAIL load_other_slots got=%h want=0", rdata1 & mask); end
    req_rd1[5] = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_all_loads();
    exp_t e;
    int n = 0;
    int last = 0;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      bank1[12'h100 + k]     = 8'hA0 ^ 8'(k * 7);
      req_addr1[k*AW +: AW]  = 12'(12'h100 + k);
      push_exp(k, 8'hA0 ^ 8'(k * 7));
    end
    @(posedge clk); #1;
    req_rd1 = 16'hFFFF;
    for (int c = 0; c < 200 && n < N; c++) begin
      @(negedge clk);
      if (done1 != '0) begin
        if (sb.size() == 0) begin
          checks++; failures++; $display("FAIL all_extra_done got=%h want=none", done1);
        end else begin
          e = sb.pop_front();
          checks++; if (done1 !== (16'(1) << e.id)) begin failures++; $display("FAIL all_order got=%h want=%h", done1, 16'(1) << e.id); end
          checks++; if (rdata1[int'(e.id)*DW +: DW] !== e.data) begin failures++; $display("FAIL all_slot%0d got=%h want=%h", e.id, rdata1[int'(e.id)*DW +: DW], e.data); end
        end
        if (n > 0) begin
          checks++; if (cyc - last !== 4) begin failures++; $display("FAIL all_spacing got=%0d want=4", cyc - last); end
        end
        last = cyc;
        req_rd1 = req_rd1 & ~done1;
        n++;
      end
    end
    checks++; if (n !== N) begin failures++; $display("FAIL all_timeout got=%0d want=%0d", n, N); end
    sb.delete();
    req_rd1 = '0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    exp_t e;
    int n = 0;
    logic [N-1:0] reassert = '0;
    req_addr1[2*AW +: AW]   = 12'h302;
    req_addr1[14*AW +: AW]  = 12'h30E;
    req_wdata1[2*DW +: DW]  = 8'h22;
    req_wdata1[14*DW +: DW] = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      push_exp(2, 8'h00);
      push_exp(14, 8'h00);
    end
    req_wr1[2] = 1'b1;
    req_wr1[14] = 1'b1;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      req_wr1 = req_wr1 | reassert;
      reassert = '0;
      if (done1 != '0) begin
        e = sb.pop_front();
        checks++; if (done1 !== (16'(1) << e.id)) begin failures++; $display("FAIL fair_grant%0d got=%h want=%h", n, done1, 16'(1) << e.id); end
        req_wr1 = req_wr1 & ~done1;
        reassert = done1;
        n++;
      end
    end
    req_wr1 = '0;
    checks++; if (n !== 6) begin failures++; $display("FAIL fair_timeout got=%0d want=6", n); end
    sb.delete();
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_rd_wr_same();
    int en_cnt = 0;
    int done_cnt = 0;
    logic we_seen = 1'b0;
    logic [7:0] slot7_exp;
    slot7_exp = 8'hA0 ^ 8'(7 * 7);
    req_addr1[7*AW +: AW]  = 12'h2F0;
    req_wdata1[7*DW +: DW] = 8'h55;
    req_rd1[7] = 1'b1;
    req_wr1[7] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_en1) begin
        en_cnt++;
        we_seen = mem_we1;
      end
      if (done1 != '0) begin
        done_cnt++;
        checks++; if (done1 !== 16'h0080) begin failures++; $display("FAIL rdwr_done_bit got=%h want=0080", done1); end
        req_rd1[7] = 1'b0;
        req_wr1[7] = 1'b0;
      end
    end
    checks++; if (en_cnt !== 1) begin failures++; $display("FAIL rdwr_access_count got=%0d want=1", en_cnt); end
    checks++; if (we_seen !== 1'b1) begin failures++; $display("FAIL rdwr_we got=%b want=1", we_seen); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rdwr_done_count got=%0d want=1", done_cnt); end
    checks++; if (rdata1[7*DW +: DW] !== slot7_exp) begin failures++; $display("FAIL rdwr_slot7 got=%h want=%h", rdata1[7*DW +: DW], slot7_exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    int n = 0;
    logic done_in_rst = 1'b0;
    bank3[12'h044] = 8'h99;
    bank3[12'h000] = 8'h11;
    bank3[12'h009] = 8'h22;
    req_addr3[4*AW +: AW] = 12'h044;
    req_addr3[0*AW +: AW] = 12'h000;
    req_addr3[9*AW +: AW] = 12'h009;
    // first a complete load on core 4 so a slot is non-zero
    push_exp(4, 8'h99);
    req_rd3[4] = 1'b1;
    for (int c = 0; c < 30 && n < 1; c++) begin
      @(negedge clk);
      if (done3 != '0) begin
        e = sb.pop_front();
        checks++; if (done3 !== (16'(1) << e.id)) begin failures++; $display("FAIL lat3_done got=%h want=%h", done3, 16'(1) << e.id); end
        checks++; if (rdata3[int'(e.id)*DW +: DW] !== e.data) begin failures++; $display("FAIL lat3_slot got=%h want=%h", rdata3[int'(e.id)*DW +: DW], e.data); end
        req_rd3[4] = 1'b0;
        n++;
      end
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL lat3_timeout got=%0d want=1", n); end
    @(posedge clk); #1;  // IDLE cycle T
    req_rd3[0] = 1'b1;
    req_rd3[9] = 1'b1;
    @(posedge clk); #1;  // T+1: ptr=4, so core 9 is next
    checks++; if ({mem_en3, grant_id3} !== 5'h19) begin failures++; $display("FAIL lat3_grant9 got=%h want=19", {mem_en3, grant_id3}); end
    repeat (2) @(posedge clk); #1;  // inside WAIT
    rst_n = 1'b0;
    #1;
    checks++; if ({done3, busy3, mem_en3, mem_we3, grant_id3} !== '0) begin failures++; $display("FAIL rst_abort_ctrl got=%h want=0", {done3, busy3, mem_en3, mem_we3, grant_id3}); end
    checks++; if ({mem_addr3, mem_wdata3} !== '0) begin failures++; $display("FAIL rst_abort_bus got=%h want=0", {mem_addr3, mem_wdata3}); end
    checks++; if (rdata3 !== '0) begin failures++; $display("FAIL rst_abort_rdata got=%h want=0", rdata3); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done3 != '0) done_in_rst = 1'b1;
    end
    checks++; if (done_in_rst !== 1'b0) begin failures++; $display("FAIL rst_abort_pulse got=1 want=0"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(0, 8'h11);
    push_exp(9, 8'h22);
    n = 0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge clk);
      if (done3 != '0) begin
        e = sb.pop_front();
        checks++; if (done3 !== (16'(1) << e.id)) begin failures++; $display("FAIL post_rst_order got=%h want=%h", done3, 16'(1) << e.id); end
        checks++; if (rdata3[int'(e.id)*DW +: DW] !== e.data) begin failures++; $display("FAIL post_rst_slot got=%h want=%h", rdata3[int'(e.id)*DW +: DW], e.data); end
        req_rd3 = req_rd3 & ~done3;
        n++;
      end
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL post_rst_timeout got=%0d want=2", n); end
    req_rd3 = '0;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_single_load();
    test_all_loads();
    test_fairness();
    test_rd_wr_same();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
